// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode encodings,
// counter direction states and the default counter width.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 32;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: compares the shared counter against this channel's active
// duty and drives a registered output at the requested polarity.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic [CNT_W-1:0] duty_act,
  input  logic             ch_en,
  input  logic             polarity,
  output logic             pwm_out
);

  logic active;

  always_comb begin
    active = ch_en && (cmp_val < duty_act);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out <= ~polarity;
    end else begin
      pwm_out <= ~(active ^ polarity);
    end
  end

endmodule

// File: rtl/multi_pwm.sv
// Multi-channel PWM with a shared edge- or centre-aligned counter and
// double-buffered period/duty registers that update on period boundaries.
module multi_pwm
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = PWM_CNT_W,
  parameter bit          CENTER = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       polarity,
  input  logic                  load,
  output logic [N_CH-1:0]       pwm_out,
  output logic                  cycle_start,
  output logic                  pending
);

  localparam pwm_mode_e        MODE = pwm_mode_e'(CENTER);
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwm_dir_e         dir_q, dir_d;
  logic [CNT_W-1:0] period_act, period_sh;
  logic [CNT_W-1:0] duty_act [N_CH];
  logic [CNT_W-1:0] duty_sh  [N_CH];
  logic [CNT_W-1:0] cmp_val;
  logic             idle, boundary, start, xfer;

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    idle     = (period_act == '0);
    if (idle) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (MODE == MODE_EDGE) begin
      if (cnt_q == period_act - ONE) begin
        boundary = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      if (dir_q == DIR_UP) begin
        if (cnt_q == period_act) begin
          cnt_d    = cnt_q - ONE;
          dir_d    = DIR_DOWN;
          boundary = (cnt_q == ONE);
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        cnt_d    = cnt_q - ONE;
        boundary = (cnt_q == ONE);
      end
      if (boundary) begin
        dir_d = DIR_UP;
      end
    end
    // An idle counter has no boundary, so a pending shadow starts a new frame directly
    start = boundary || (idle && pending);
    xfer  = start && pending;
    if (xfer) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end
  end

  // Down-count compares against cnt-1 so the frame has 2*duty active cycles around the valley
  always_comb begin
    cmp_val = (dir_q == DIR_DOWN) ? (cnt_q - ONE) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      period_act  <= '0;
      period_sh   <= '0;
      pending     <= 1'b0;
      cycle_start <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        duty_act[k] <= '0;
        duty_sh[k]  <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      cycle_start <= start;
      pending     <= load || (pending && !xfer);
      if (xfer) begin
        period_act <= period_sh;
        for (int unsigned k = 0; k < N_CH; k++) begin
          duty_act[k] <= duty_sh[k];
        end
      end
      if (load) begin
        period_sh <= period;
        for (int unsigned k = 0; k < N_CH; k++) begin
          duty_sh[k] <= (duty[k*CNT_W +: CNT_W] > period) ? period : duty[k*CNT_W +: CNT_W];
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .cmp_val (cmp_val),
      .duty_act(duty_act[g]),
      .ch_en   (ch_en[g]),
      .polarity(polarity[g]),
      .pwm_out (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_multi_pwm.sv
// Directed self-checking bench for multi_pwm: one edge-aligned and one
// centre-aligned instance share the same stimulus.
module tb_multi_pwm;

  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] period;
  logic [N*W-1:0] duty;
  logic [N-1:0] ch_en, polarity;
  logic         load;
  logic [N-1:0] pwm_e, pwm_c;
  logic         cs_e, cs_c, pend_e, pend_c;

  int checks = 0;
  int errors = 0;
  int hi [N];
  int cs_cnt, cs_pos;
  logic [15:0] pat_c;

  always #5 clk = ~clk;

  multi_pwm #(.N_CH(N), .CNT_W(W), .CENTER(1'b0)) dut_edge (
    .clk(clk), .reset(reset), .period(period), .duty(duty), .ch_en(ch_en),
    .polarity(polarity), .load(load), .pwm_out(pwm_e), .cycle_start(cs_e),
    .pending(pend_e)
  );

  multi_pwm #(.N_CH(N), .CNT_W(W), .CENTER(1'b1)) dut_ctr (
    .clk(clk), .reset(reset), .period(period), .duty(duty), .ch_en(ch_en),
    .polarity(polarity), .load(load), .pwm_out(pwm_c), .cycle_start(cs_c),
    .pending(pend_c)
  );

  task automatic do_reset;
    reset = 1'b0;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic apply_load(input logic [W-1:0] p, input logic [N*W-1:0] d);
    @(negedge clk);
    period = p;
    duty   = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_start(input bit ctr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ctr ? cs_c : cs_e) ok = 1'b1;
    end
  endtask

  task automatic measure(input int n, input bit ctr);
    for (int ch = 0; ch < N; ch++) hi[ch] = 0;
    cs_cnt = 0;
    cs_pos = 0;
    pat_c  = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < N; ch++) hi[ch] += int'(pwm_e[ch]);
      if (ctr ? cs_c : cs_e) begin
        cs_cnt++;
        cs_pos = i;
      end
      if (i <= 16) pat_c[i-1] = pwm_c[0];
    end
  endtask

  task automatic test_reset;
    polarity = 4'b0110;
    ch_en    = 4'b1111;
    reset    = 1'b0;
    load     = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pwm_e !== 4'b1001) begin
      errors++; $display("FAIL reset_pwm_edge: got %b expected %b", pwm_e, 4'b1001);
    end
    checks++;
    if (pwm_c !== 4'b1001) begin
      errors++; $display("FAIL reset_pwm_ctr: got %b expected %b", pwm_c, 4'b1001);
    end
    checks++;
    if ({cs_e, pend_e, cs_c, pend_c} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {cs_e, pend_e, cs_c, pend_c});
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (pwm_e !== 4'b1001 || cs_e !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got pwm=%b cs=%b expected pwm=1001 cs=0", pwm_e, cs_e);
    end
  endtask

  task automatic test_edge;
    bit ok;
    polarity = 4'b1111;
    ch_en    = 4'b1111;
    do_reset();
    apply_load(32'd10, {32'd15, 32'd10, 32'd3, 32'd0});
    wait_start(1'b0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL edge_start_timeout: got no cycle_start expected one");
    end
    measure(10, 1'b0);
    for (int ch = 0; ch < N; ch++) begin
      checks++;
      if (hi[ch] !== ((ch == 0) ? 0 : (ch == 1) ? 3 : 10)) begin
        errors++; $display("FAIL edge_ch%0d_high: got %0d expected %0d", ch, hi[ch],
                           (ch == 0) ? 0 : (ch == 1) ? 3 : 10);
      end
    end
    checks++;
    if (cs_cnt !== 1 || cs_pos !== 10) begin
      errors++; $display("FAIL edge_cycle_start: got cnt=%0d pos=%0d expected cnt=1 pos=10", cs_cnt, cs_pos);
    end
    measure(10, 1'b0);
    checks++;
    if (cs_cnt !== 1 || cs_pos !== 10 || hi[1] !== 3) begin
      errors++; $display("FAIL edge_second_period: got cs=%0d pos=%0d hi1=%0d expected 1 10 3", cs_cnt, cs_pos, hi[1]);
    end
  endtask

  task automatic test_reload;
    bit ok;
    bit pend_ok;
    int c1, c2;
    polarity = 4'b1111;
    ch_en    = 4'b1111;
    do_reset();
    apply_load(32'd10, {96'd0, 32'd4});
    wait_start(1'b0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL reload_start_timeout: got no cycle_start expected one");
    end
    c1 = 0; c2 = 0; pend_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i <= 10) c1 += int'(pwm_e[0]);
      else c2 += int'(pwm_e[0]);
      if (i >= 6 && i <= 9 && pend_e !== 1'b1) pend_ok = 1'b0;
      if (i == 10) begin
        checks++;
        if (pend_e !== 1'b0 || cs_e !== 1'b1) begin
          errors++; $display("FAIL reload_boundary: got pend=%b cs=%b expected pend=0 cs=1", pend_e, cs_e);
        end
      end
      if (i == 5) begin
        duty = {96'd0, 32'd7};
        load = 1'b1;
      end
      if (i == 6) load = 1'b0;
    end
    checks++;
    if (!pend_ok) begin
      errors++; $display("FAIL reload_pending: got low before boundary expected high");
    end
    checks++;
    if (c1 !== 4) begin
      errors++; $display("FAIL reload_cur_period: got %0d expected 4", c1);
    end
    checks++;
    if (c2 !== 7) begin
      errors++; $display("FAIL reload_next_period: got %0d expected 7", c2);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int c [3];
    polarity = 4'b1111;
    ch_en    = 4'b1111;
    do_reset();
    apply_load(32'd10, {96'd0, 32'd2});
    wait_start(1'b0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_start_timeout: got no cycle_start expected one");
    end
    for (int p = 0; p < 3; p++) c[p] = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      c[(i-1)/10] += int'(pwm_e[0]);
      if (i == 10) begin
        checks++;
        if (pend_e !== 1'b1 || cs_e !== 1'b1) begin
          errors++; $display("FAIL b2b_pending_kept: got pend=%b cs=%b expected pend=1 cs=1", pend_e, cs_e);
        end
      end
      if (i == 20) begin
        checks++;
        if (pend_e !== 1'b0 || cs_e !== 1'b1) begin
          errors++; $display("FAIL b2b_pending_clear: got pend=%b cs=%b expected pend=0 cs=1", pend_e, cs_e);
        end
      end
      if (i == 1) begin duty = {96'd0, 32'd5}; load = 1'b1; end
      if (i == 2) load = 1'b0;
      if (i == 9) begin duty = {96'd0, 32'd8}; load = 1'b1; end
      if (i == 10) load = 1'b0;
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (c[p] !== ((p == 0) ? 2 : (p == 1) ? 5 : 8)) begin
        errors++; $display("FAIL b2b_period%0d: got %0d expected %0d", p, c[p], (p == 0) ? 2 : (p == 1) ? 5 : 8);
      end
    end
  endtask

  task automatic test_centre;
    bit ok;
    polarity = 4'b1111;
    ch_en    = 4'b1111;
    do_reset();
    apply_load(32'd8, {96'd0, 32'd3});
    wait_start(1'b1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL centre_start_timeout: got no cycle_start expected one");
    end
    measure(16, 1'b1);
    checks++;
    if (pat_c !== 16'hE007) begin
      errors++; $display("FAIL centre_pattern: got %h expected e007", pat_c);
    end
    checks++;
    if (cs_cnt !== 1 || cs_pos !== 16) begin
      errors++; $display("FAIL centre_cycle_start: got cnt=%0d pos=%0d expected cnt=1 pos=16", cs_cnt, cs_pos);
    end
  endtask

  task automatic test_polarity;
    bit ok;
    polarity = 4'b1011;
    ch_en    = 4'b1011;
    do_reset();
    apply_load(32'd5, {4{32'd2}});
    wait_start(1'b0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL pol_start_timeout: got no cycle_start expected one");
    end
    measure(5, 1'b0);
    checks++;
    if (hi[2] !== 5) begin
      errors++; $display("FAIL pol_disabled_ch2: got %0d high expected 5", hi[2]);
    end
    checks++;
    if (hi[0] !== 2) begin
      errors++; $display("FAIL pol_ch0: got %0d high expected 2", hi[0]);
    end
    ch_en = 4'b1111;
    wait_start(1'b0, ok);
    measure(5, 1'b0);
    checks++;
    if (hi[2] !== 3) begin
      errors++; $display("FAIL pol_enabled_ch2: got %0d high expected 3", hi[2]);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    int bad;
    polarity = 4'b1111;
    ch_en    = 4'b1111;
    do_reset();
    apply_load(32'd10, {4{32'd8}});
    wait_start(1'b0, ok);
    repeat (6) @(negedge clk);
    checks++;
    if (pwm_e !== 4'b1111) begin
      errors++; $display("FAIL midrst_before: got %b expected 1111", pwm_e);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pwm_e !== 4'b0000 || pend_e !== 1'b0 || cs_e !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got pwm=%b pend=%b cs=%b expected 0000 0 0", pwm_e, pend_e, cs_e);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (pwm_e !== 4'b0000 || cs_e !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL midrst_idle: got %0d active cycles expected 0", bad);
    end
    apply_load(32'd10, {4{32'd8}});
    wait_start(1'b0, ok);
    measure(10, 1'b0);
    checks++;
    if (hi[0] !== 8 || cs_pos !== 10) begin
      errors++; $display("FAIL midrst_reload: got hi=%0d pos=%0d expected 8 10", hi[0], cs_pos);
    end
  endtask

  initial begin
    reset    = 1'b0;
    load     = 1'b0;
    period   = '0;
    duty     = '0;
    ch_en    = '0;
    polarity = '1;
    test_reset();
    test_edge();
    test_reload();
    test_back_to_back();
    test_centre();
    test_polarity();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pwm.md
MULTI_PWM -- requirements
Module: multi_pwm

Interface
REQ-001 Parameter N_CH, default 4, number of PWM channels (one per motor).
REQ-002 Parameter CNT_W, default 32, width of the counter, period and duty fields.
REQ-003 Parameter CENTER, default 0; 0 selects edge-aligned mode, 1 selects centre-aligned mode.
REQ-004 clk  in  1  sole clock; all logic SHALL be rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 period  in  CNT_W  requested period in clk cycles (edge mode) or half-period (centre mode).
REQ-007 duty  in  N_CH*CNT_W  requested per-channel active time; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-008 ch_en  in  N_CH  per-channel enable; a disabled channel drives its inactive level.
REQ-009 polarity  in  N_CH  per-channel active level: 1 = active-high, 0 = active-low.
REQ-010 load  in  1  single-cycle strobe that captures period and duty into the shadow registers.
REQ-011 pwm_out  out  N_CH  registered PWM outputs.
REQ-012 cycle_start  out  1  one-cycle pulse at each period boundary.
REQ-013 pending  out  1  high while shadow values await transfer to the active registers.

Function
REQ-014 load SHALL copy period and duty into the shadow registers and set pending on the next edge.
REQ-015 A shadow duty greater than the shadow period SHALL be clamped to the period at capture (100 %).
REQ-016 At a boundary with pending=1, shadow values SHALL move to the active registers and pending SHALL clear.
REQ-017 If load coincides with a boundary, the previously pending shadow (if any) SHALL transfer, the new values SHALL enter the shadow, and pending SHALL stay 1.
REQ-018 Edge mode: the counter SHALL count 0..period_act-1 and then wrap to 0; the boundary is the cycle in which the counter equals period_act-1.
REQ-019 Centre mode: the counter SHALL count up 0..period_act, then down to 0; the boundary is the down-count reaching 0; total cycle length is 2*period_act.
REQ-020 A channel SHALL be active when ch_en=1 and counter < duty_act; pwm_out SHALL equal that value XNOR polarity, registered, with 1 cycle of latency from the counter.
REQ-021 duty_act=0 SHALL produce a constant inactive level; duty_act=period_act SHALL produce a constant active level (edge mode).
REQ-022 With period_act=0, the counter SHALL hold 0, all outputs SHALL be inactive, and any pending shadow SHALL transfer on the next cycle.
REQ-023 cycle_start SHALL pulse on the cycle after each boundary, aligned with counter=0 of the new cycle.
REQ-024 Changes to ch_en or polarity SHALL take effect on the next pwm_out update, with no shadowing.
REQ-025 Counter arithmetic SHALL be CNT_W-bit unsigned and SHALL never overflow for any period ≤ 2^CNT_W-1.

Reset
REQ-026 While reset=0: counter, active and shadow registers, and pending SHALL be 0; cycle_start SHALL be 0; pwm_out[k] SHALL be ~polarity[k].
REQ-027 Reset asserted mid-period SHALL abort the cycle immediately; after release, counting SHALL restart from 0 with period_act=0 until a load occurs.

Structure
REQ-028 Mode encodings (EDGE=0, CENTER=1) and the default CNT_W SHALL live in the shared pwm_pkg package.
REQ-029 The shared counter and boundary logic SHALL sit in the top level; the per-channel compare and polarity logic SHALL be one sub-module, pwm_channel, instantiated N_CH times in a generate loop.

Verification
REQ-030 Edge mode: load period=10, duty={0,3,10,15} with all polarity=1 -> channels give 0, 3, 10 and 10 high cycles per 10; cycle_start every 10 cycles.
REQ-031 Mid-period reload: period=10, duty0=4 running; at counter=5 load duty0=7 -> the current period keeps 4 high cycles, the next has 7; pending is high from the load until the boundary.
REQ-032 Load at boundary: load coincident with counter=9 -> the old pending values apply, the new values apply one period later, and pending stays 1 across the boundary.
REQ-033 Centre mode: period=8, duty=3 -> 16-cycle frame with 6 active cycles centred on the counter=0 valley; cycle_start every 16 cycles.
REQ-034 polarity=0, ch_en=0 on channel 2 -> pwm_out[2] is constantly 1; with ch_en=1 and duty=2, period=5 -> low for 2 cycles out of 5.
REQ-035 Assert reset at counter=6 of 10 -> all outputs go inactive asynchronously; after release, outputs stay inactive until a load with period≠0.
